// File: rtl/pe_config_loader_pkg.sv
// Shared definitions for the PE configuration loader: default geometry,
// FSM state encoding and the words-per-context derivation.
package pe_config_loader_pkg;

   // Defaults kept consistent with the PE array's per-row config width.
   localparam int unsigned ROWS_DEFAULT     = 4;
   localparam int unsigned CONFIG_W_DEFAULT = 64;
   localparam int unsigned WORD_W_DEFAULT   = 32;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StDrain,
      StInit,
      StRun,
      StDone
   } state_e;

   // SRAM words needed to hold one complete context.
   function automatic int unsigned calc_nwords(input int unsigned rows,
                                               input int unsigned config_w,
                                               input int unsigned word_w);
      return rows * config_w / word_w;
   endfunction

endpackage

// File: rtl/pe_config_loader_if.sv
// Read port of the synchronous configuration SRAM. The loader is the master;
// the SRAM returns data one cycle after the read strobe.
interface pe_config_loader_if
   import pe_config_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned WORD_W = WORD_W_DEFAULT
);
   logic              cfg_rd_en;
   logic [ADDR_W-1:0] cfg_rd_addr;
   logic [WORD_W-1:0] cfg_rd_data;

   modport master (
      output cfg_rd_en,
      output cfg_rd_addr,
      input  cfg_rd_data
   );

   modport slave (
      input  cfg_rd_en,
      input  cfg_rd_addr,
      output cfg_rd_data
   );
endinterface

// File: rtl/pe_config_loader.sv
// Fetches one configuration context from the config SRAM, publishes it to the
// PE array between executions, then sequences init and a counted run phase.
module pe_config_loader
   import pe_config_loader_pkg::*;
#(
   parameter int unsigned ROWS     = ROWS_DEFAULT,
   parameter int unsigned CONFIG_W = CONFIG_W_DEFAULT,
   parameter int unsigned WORD_W   = WORD_W_DEFAULT,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned CTX_W    = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic [CTX_W-1:0]         i_ctx_id,
   input  logic [CNT_W-1:0]         i_run_cycles,
   input  logic                     i_abort,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [ROWS*CONFIG_W-1:0] o_pe_config,
   output logic                     o_init,
   output logic                     o_run,
   pe_config_loader_if.master       io_cfg
);

   localparam int unsigned NWORDS = calc_nwords(ROWS, CONFIG_W, WORD_W);
   localparam int unsigned CFG_W  = ROWS * CONFIG_W;
   localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   state_e              r_state;
   state_e              w_state_nxt;
   logic                w_start;
   logic [ADDR_W-1:0]   w_base;
   logic [CFG_W-1:0]    w_buf_nxt;

   logic                r_busy;
   logic                r_done;
   logic                r_init;
   logic                r_run;
   logic                r_rd_en;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic [IDX_W-1:0]    r_rd_idx;
   logic                r_cap_vld;
   logic [IDX_W-1:0]    r_cap_idx;
   logic [CFG_W-1:0]    r_buf;
   logic [CFG_W-1:0]    r_pe_config;
   logic [CNT_W-1:0]    r_cnt;

   // Context base address; wraps modulo the SRAM address space.
   assign w_base = ADDR_W'(32'(i_ctx_id) * NWORDS);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_nxt = StLoad;
               w_start     = 1'b1;
            end
         end
         StLoad: begin
            if (r_rd_idx == IDX_W'(NWORDS - 1)) begin
               w_state_nxt = StDrain;
            end
         end
         StDrain: w_state_nxt = StInit;
         StInit:  w_state_nxt = (r_cnt != '0) ? StRun : StDone;
         StRun: begin
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = StDone;
            end
         end
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
      if (i_abort) begin
         w_state_nxt = StIdle;
         w_start     = 1'b0;
      end
   end

   // Merge the word returned by last cycle's read into the load buffer.
   always_comb begin
      w_buf_nxt = r_buf;
      if (r_cap_vld) begin
         w_buf_nxt[int'(r_cap_idx) * WORD_W +: WORD_W] = io_cfg.cfg_rd_data;
      end
   end

   // Registered outputs, read sequencing, load buffer and run counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_init      <= 1'b0;
         r_run       <= 1'b0;
         r_rd_en     <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_idx    <= '0;
         r_cap_vld   <= 1'b0;
         r_cap_idx   <= '0;
         r_buf       <= '0;
         r_pe_config <= '0;
         r_cnt       <= '0;
      end else begin
         r_busy    <= (w_state_nxt != StIdle);
         r_done    <= (w_state_nxt == StDone);
         r_init    <= (w_state_nxt == StInit);
         r_run     <= (w_state_nxt == StRun);
         r_rd_en   <= (w_state_nxt == StLoad);
         r_cap_vld <= r_rd_en;
         r_cap_idx <= r_rd_idx;
         r_buf     <= w_buf_nxt;
         if (w_start) begin
            r_rd_addr <= w_base;
            r_rd_idx  <= '0;
            r_cnt     <= i_run_cycles;
         end else if (r_state == StLoad && w_state_nxt == StLoad) begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
            r_rd_idx  <= r_rd_idx + IDX_W'(1);
         end
         if (r_state == StRun) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         // Only a completed load reaches the array; an abort in DRAIN keeps the old one.
         if (r_state == StDrain && w_state_nxt == StInit) begin
            r_pe_config <= w_buf_nxt;
         end
      end
   end

   assign o_busy             = r_busy;
   assign o_done             = r_done;
   assign o_init             = r_init;
   assign o_run              = r_run;
   assign o_pe_config        = r_pe_config;
   assign io_cfg.cfg_rd_en   = r_rd_en;
   assign io_cfg.cfg_rd_addr = r_rd_addr;

endmodule
